// File: rtl/jtframe_ba_arb_if.sv
// Bundle of slot-side request/response signals and SDRAM bank-side handshake
// used by the bank arbiter with its per-slot one-word cache.
interface jtframe_ba_arb_if #(
  parameter int unsigned SDRAMW = 22,
  parameter int unsigned SLOTS  = 4
);
  logic                      downloading;
  logic [SLOTS*SDRAMW-1:0]   slot_addr;
  logic [SLOTS-1:0]          slot_cs;
  logic [SLOTS-1:0]          slot_ok;
  logic [SLOTS*16-1:0]       slot_dout;
  logic [SDRAMW-1:0]         ba_addr;
  logic                      ba_rd;
  logic                      ba_ack;
  logic                      ba_rdy;
  logic [15:0]               sdram_dout;

  // Arbiter side
  modport slave (
    input  downloading, slot_addr, slot_cs, ba_ack, ba_rdy, sdram_dout,
    output slot_ok, slot_dout, ba_addr, ba_rd
  );

  // Requesters plus SDRAM controller side
  modport master (
    output downloading, slot_addr, slot_cs, ba_ack, ba_rdy, sdram_dout,
    input  slot_ok, slot_dout, ba_addr, ba_rd
  );
endinterface

// File: rtl/jtframe_ba_arb.sv
// Round-robin SDRAM bank arbiter: each slot has a one-word cache; misses are
// serviced one at a time through a ba_rd/ba_ack/ba_rdy handshake.
module jtframe_ba_arb #(
  parameter int unsigned SDRAMW = 22,
  parameter int unsigned SLOTS  = 4
)(
  input  logic            clk,
  input  logic            rst,
  jtframe_ba_arb_if.slave bus
);

  localparam int unsigned IW = $clog2(SLOTS);
  localparam int unsigned DW = 16;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_ACK = 2'd1;
  localparam logic [1:0] WAIT_RDY = 2'd2;

  logic [1:0]        state, state_nx;
  logic [IW-1:0]     gnt, gnt_nx;
  logic [IW-1:0]     last, last_nx;
  logic [IW-1:0]     pick;
  logic              found;
  logic [SDRAMW-1:0] addr_nx;
  logic              rd_nx;
  logic              fill;

  logic [SDRAMW-1:0] tag  [SLOTS];
  logic [DW-1:0]     data [SLOTS];
  logic [SLOTS-1:0]  valid;
  logic [SLOTS-1:0]  hit;
  logic [SLOTS-1:0]  pending;
  logic [SLOTS*DW-1:0] dout_c;

  // Zero-latency hit detection and cached data fan-out
  always_comb begin
    hit    = '0;
    dout_c = '0;
    for (int unsigned n = 0; n < SLOTS; n++) begin
      hit[n] = bus.slot_cs[n] & valid[n] &
               (bus.slot_addr[n*SDRAMW +: SDRAMW] == tag[n]);
      dout_c[n*DW +: DW] = data[n];
    end
  end

  assign pending       = bus.slot_cs & ~hit;
  assign bus.slot_ok   = hit;
  assign bus.slot_dout = dout_c;

  // Round-robin search beginning just after the last served slot
  always_comb begin
    pick  = last;
    found = 1'b0;
    for (int unsigned k = 1; k <= SLOTS; k++) begin
      logic [IW-1:0] idx;
      idx = IW'((32'(last) + k) % SLOTS);
      if (!found && pending[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // Next-state and registered-output decode
  always_comb begin
    state_nx = state;
    gnt_nx   = gnt;
    last_nx  = last;
    addr_nx  = bus.ba_addr;
    rd_nx    = bus.ba_rd;
    fill     = 1'b0;
    case (state)
      IDLE: begin
        rd_nx = 1'b0;
        if (!bus.downloading && found) begin
          state_nx = WAIT_ACK;
          gnt_nx   = pick;
          addr_nx  = bus.slot_addr[32'(pick)*SDRAMW +: SDRAMW];
          rd_nx    = 1'b1;
        end
      end
      WAIT_ACK: begin
        if (bus.ba_ack) begin
          rd_nx = 1'b0;
          if (bus.ba_rdy) begin
            fill     = 1'b1;
            state_nx = IDLE;
          end else begin
            state_nx = WAIT_RDY;
          end
        end
      end
      WAIT_RDY: begin
        if (bus.ba_rdy) begin
          fill     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
        rd_nx    = 1'b0;
      end
    endcase
    if (fill) last_nx = gnt;
  end

  // State, handshake outputs and cache storage; a download clear beats a fill
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      gnt         <= '0;
      last        <= IW'(SLOTS-1);
      bus.ba_rd   <= 1'b0;
      bus.ba_addr <= '0;
      valid       <= '0;
      for (int unsigned n = 0; n < SLOTS; n++) begin
        tag[n]  <= '0;
        data[n] <= '0;
      end
    end else begin
      state       <= state_nx;
      gnt         <= gnt_nx;
      last        <= last_nx;
      bus.ba_rd   <= rd_nx;
      bus.ba_addr <= addr_nx;
      if (fill) begin
        data[gnt] <= bus.sdram_dout;
        tag[gnt]  <= bus.ba_addr;
      end
      if (bus.downloading) valid <= '0;
      else if (fill)       valid[gnt] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_jtframe_ba_arb.sv
// Bench for jtframe_ba_arb: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a transaction-level model.
module tb_jtframe_ba_arb;

  localparam int unsigned AW = 22;
  localparam int unsigned NS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  jtframe_ba_arb_if #(.SDRAMW(AW), .SLOTS(NS)) bus();

  jtframe_ba_arb #(.SDRAMW(AW), .SLOTS(NS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: cache contents plus the one outstanding transaction
  logic [AW-1:0] m_tag   [NS];
  logic [15:0]   m_data  [NS];
  bit            m_valid [NS];
  bit            m_busy, m_acked;
  int            m_g, m_last;
  logic [AW-1:0] m_ba_addr;
  bit            started = 0;

  function automatic logic [AW-1:0] saddr(input int n);
    return bus.slot_addr[n*AW +: AW];
  endfunction

  function automatic bit exp_ok(input int n);
    return bus.slot_cs[n] && m_valid[n] && (saddr(n) == m_tag[n]);
  endfunction

  always @(posedge clk) begin : model
    bit fill;
    int pick;
    fill = 0;
    pick = -1;
    if (rst) begin
      started   = 1;
      m_busy    = 0;
      m_acked   = 0;
      m_g       = 0;
      m_last    = NS - 1;
      m_ba_addr = '0;
      for (int n = 0; n < NS; n++) begin
        m_tag[n] = '0; m_data[n] = '0; m_valid[n] = 0;
      end
    end else if (started) begin
      if (!m_busy) begin
        if (!bus.downloading)
          for (int k = 1; k <= NS; k++) begin
            int idx;
            idx = (m_last + k) % NS;
            if (pick < 0 && bus.slot_cs[idx] && !exp_ok(idx)) pick = idx;
          end
        if (pick >= 0) begin
          m_busy = 1; m_acked = 0; m_g = pick; m_ba_addr = saddr(pick);
        end
      end else if (!m_acked) begin
        if (bus.ba_ack) begin
          if (bus.ba_rdy) fill = 1;
          else            m_acked = 1;
        end
      end else if (bus.ba_rdy) begin
        fill = 1;
      end
      if (fill) begin
        m_data[m_g]  = bus.sdram_dout;
        m_tag[m_g]   = m_ba_addr;
        m_valid[m_g] = 1;
        m_last       = m_g;
        m_busy       = 0;
      end
      if (bus.downloading)
        for (int n = 0; n < NS; n++) m_valid[n] = 0;
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (started) begin
      chk("ba_rd", 32'(bus.ba_rd), 32'(m_busy && !m_acked));
      if (m_busy && !m_acked) chk("ba_addr", 32'(bus.ba_addr), 32'(m_ba_addr));
      for (int n = 0; n < NS; n++) begin
        chk($sformatf("slot_ok%0d", n), 32'(bus.slot_ok[n]), 32'(exp_ok(n)));
        chk($sformatf("slot_dout%0d", n), 32'(bus.slot_dout[n*16 +: 16]), 32'(m_data[n]));
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_slot(input int n, input logic [AW-1:0] a, input bit cs);
    bus.slot_addr[n*AW +: AW] = a;
    bus.slot_cs[n]            = cs;
  endtask

  task automatic wait_rd(output bit ok);
    int w;
    w = 0;
    while (!bus.ba_rd && w < 20) begin tick(); w++; end
    ok = (w < 20);
    if (!ok) chk("ba_rd_timeout", 32'(bus.ba_rd), 32'd1);
  endtask

  // Acknowledge on the first ba_rd cycle, data one cycle later
  task automatic serve(input logic [15:0] d, output logic [AW-1:0] a);
    bit ok;
    wait_rd(ok);
    a = ok ? bus.ba_addr : '0;
    if (ok) begin
      bus.ba_ack = 1; tick();
      bus.ba_ack = 0; bus.ba_rdy = 1; bus.sdram_dout = d; tick();
      bus.ba_rdy = 0;
    end
  endtask

  logic [AW-1:0] a;
  logic [AW-1:0] pool [4];
  bit            okw;

  initial begin
    pool[0] = 22'h000000; pool[1] = 22'h200000; pool[2] = 22'h3FFFFF; pool[3] = 22'h000011;
    bus.downloading = 0; bus.ba_ack = 0; bus.ba_rdy = 0; bus.sdram_dout = '0;
    bus.slot_addr = '0; bus.slot_cs = '1;

    // Reset state: all cs high at address 0 must still miss
    tick(); tick(); #1;
    chk("rst_ba_rd", 32'(bus.ba_rd), 32'd0);
    chk("rst_ba_addr", 32'(bus.ba_addr), 32'd0);
    chk("rst_slot_ok", 32'(bus.slot_ok), 32'd0);
    chk("rst_dout0", 32'(bus.slot_dout[15:0]), 32'd0);
    bus.slot_cs = '0; rst = 0;

    // Single miss: ok four cycles after cs
    tick(); set_slot(0, 22'h1234, 1); #1;
    chk("miss_ok_c0", 32'(bus.slot_ok[0]), 32'd0);
    tick(); #1;
    chk("miss_rd", 32'(bus.ba_rd), 32'd1);
    chk("miss_addr", 32'(bus.ba_addr), 32'h1234);
    bus.ba_ack = 1;
    tick(); bus.ba_ack = 0; #1;
    chk("miss_rd_pulse", 32'(bus.ba_rd), 32'd0);
    tick(); bus.ba_rdy = 1; bus.sdram_dout = 16'hBEEF; #1;
    chk("miss_ok_c3", 32'(bus.slot_ok[0]), 32'd0);
    tick(); bus.ba_rdy = 0; #1;
    chk("miss_ok_c4", 32'(bus.slot_ok[0]), 32'd1);
    chk("miss_dout", 32'(bus.slot_dout[15:0]), 32'hBEEF);

    // Hit: same-cycle ok, no bank traffic
    set_slot(0, 22'h1234, 0); tick();
    set_slot(0, 22'h1234, 1); #1;
    chk("hit_ok", 32'(bus.slot_ok[0]), 32'd1);
    tick(); #1; chk("hit_no_rd0", 32'(bus.ba_rd), 32'd0);
    tick(); #1; chk("hit_no_rd1", 32'(bus.ba_rd), 32'd0);

    // Round-robin after reset
    bus.slot_cs = '0; rst = 1; tick(); tick(); rst = 0;
    for (int n = 0; n < NS; n++) set_slot(n, AW'(32'h100 + n), 1);
    for (int i = 0; i < NS; i++) begin
      serve(16'hA000 + 16'(i), a);
      chk($sformatf("rr1_order%0d", i), 32'(a), 32'h100 + i);
    end
    set_slot(1, 22'h201, 1);
    serve(16'hA101, a);
    chk("rr_slot1", 32'(a), 32'h201);
    set_slot(0, 22'h300, 1); set_slot(2, 22'h302, 1); set_slot(3, 22'h303, 1);
    serve(16'hB002, a); chk("rr2_order0", 32'(a), 32'h302);
    serve(16'hB003, a); chk("rr2_order1", 32'(a), 32'h303);
    serve(16'hB000, a); chk("rr2_order2", 32'(a), 32'h300);

    // Simultaneous ack and rdy; last served was slot 0 so slot 1 goes first
    set_slot(2, 22'h302, 0); set_slot(3, 22'h303, 0);
    set_slot(0, 22'h400, 1); set_slot(1, 22'h401, 1);
    wait_rd(okw);
    chk("both_addr", 32'(bus.ba_addr), 32'h401);
    bus.ba_ack = 1; bus.ba_rdy = 1; bus.sdram_dout = 16'h5555;
    tick(); bus.ba_ack = 0; bus.ba_rdy = 0; #1;
    chk("both_idle_rd", 32'(bus.ba_rd), 32'd0);
    chk("both_ok1", 32'(bus.slot_ok[1]), 32'd1);
    chk("both_dout1", 32'(bus.slot_dout[31:16]), 32'h5555);
    tick(); #1;
    chk("both_next_rd", 32'(bus.ba_rd), 32'd1);
    chk("both_next_addr", 32'(bus.ba_addr), 32'h400);
    serve(16'h6666, a);

    // Download clears the cache and blocks requests while held
    set_slot(0, 22'h400, 0); #1;
    chk("dl_pre_ok1", 32'(bus.slot_ok[1]), 32'd1);
    bus.downloading = 1; tick(); bus.downloading = 0; #1;
    chk("dl_post_ok1", 32'(bus.slot_ok[1]), 32'd0);
    bus.downloading = 1;
    for (int i = 0; i < 3; i++) begin
      tick(); #1; chk($sformatf("dl_hold_rd%0d", i), 32'(bus.ba_rd), 32'd0);
    end
    bus.downloading = 0;
    tick(); #1;
    chk("dl_release_rd", 32'(bus.ba_rd), 32'd1);
    chk("dl_release_addr", 32'(bus.ba_addr), 32'h401);
    serve(16'h7777, a);

    // Reset during WAIT_RDY: late rdy ignored, slot 0 granted first
    set_slot(1, 22'h401, 0); set_slot(0, 22'h600, 1); set_slot(2, 22'h500, 1);
    wait_rd(okw);
    chk("rstmid_addr", 32'(bus.ba_addr), 32'h500);
    bus.ba_ack = 1; tick(); bus.ba_ack = 0;
    rst = 1; tick(); rst = 0;
    bus.ba_rdy = 1; bus.sdram_dout = 16'hDEAD; #1;
    chk("rstmid_rd", 32'(bus.ba_rd), 32'd0);
    chk("rstmid_ok2", 32'(bus.slot_ok[2]), 32'd0);
    tick(); bus.ba_rdy = 0; #1;
    chk("rstmid_grant_rd", 32'(bus.ba_rd), 32'd1);
    chk("rstmid_grant_addr", 32'(bus.ba_addr), 32'h600);
    chk("rstmid_ok2b", 32'(bus.slot_ok[2]), 32'd0);
    serve(16'h1111, a);
    serve(16'h2222, a);
    chk("rstmid_regrant", 32'(a), 32'h500);
    #1;
    chk("rstmid_dout2", 32'(bus.slot_dout[47:32]), 32'h2222);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int n = 0; n < NS; n++)
        if ($urandom_range(3) == 0) set_slot(n, pool[$urandom_range(3)], bit'($urandom_range(1)));
      bus.downloading = ($urandom_range(24) == 0);
      rst             = ($urandom_range(299) == 0);
      bus.ba_ack      = ($urandom_range(2) == 0);
      bus.ba_rdy      = ($urandom_range(2) == 0);
      bus.sdram_dout  = 16'($urandom);
    end
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
